// File: rtl/sally_bus_arbiter.sv
// sally_bus_arbiter: hands the shared system address bus between the 6502 and MARIA DMA.
// Halts the CPU on pclk1, grants MARIA once the CPU lets go, and returns the bus afterwards.
module sally_bus_arbiter #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int MAX_DMA_CYCLES = 512
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pclk0,
    input  logic        pclk1,
    input  logic        halt_en,
    input  logic        dma_req,
    input  logic        dma_done,
    input  logic [15:0] cpu_AB,
    input  logic        cpu_rwn,
    input  logic        cpu_halted,
    input  logic [15:0] maria_AB,
    output logic        cpu_halt_n,
    output logic        dma_grant,
    output logic [15:0] AB,
    output logic        RW,
    output logic [2:0]  state_o,
    output logic [15:0] steal_count,
    output logic        wd_fired
);
    localparam int WDW = $clog2(MAX_DMA_CYCLES + 1);

    typedef enum logic [2:0] {
        CPU_OWN  = 3'd0,
        HALT_REQ = 3'd1,
        SETTLE   = 3'd2,
        DMA_OWN  = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t         r_state, w_nxt_state;
    logic [1:0]     r_settle, w_nxt_settle;
    logic [WDW-1:0] r_wd, w_nxt_wd, w_wd_inc;
    logic [15:0]    r_steal, w_nxt_steal;
    logic           r_wd_fired, w_nxt_wd_fired;
    logic           r_done_lat, w_nxt_done_lat;
    logic           w_done;
    logic [15:0]    r_held;
    logic [15:0]    w_ab;
    logic           w_rw;
    logic           w_halt_n;
    logic           w_grant;
    logic           w_unused_pclk0;

    assign w_unused_pclk0 = pclk0;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= CPU_OWN;
            r_settle   <= '0;
            r_wd       <= '0;
            r_steal    <= '0;
            r_wd_fired <= 1'b0;
            r_done_lat <= 1'b0;
            r_held     <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_settle   <= w_nxt_settle;
            r_wd       <= w_nxt_wd;
            r_steal    <= w_nxt_steal;
            r_wd_fired <= w_nxt_wd_fired;
            r_done_lat <= w_nxt_done_lat;
            // Track whoever is actually driving so hand-over cycles repeat it.
            if (r_state == CPU_OWN || r_state == HALT_REQ || r_state == DMA_OWN)
                r_held <= w_ab;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_settle   = r_settle;
        w_nxt_wd       = '0;
        w_nxt_steal    = r_steal;
        w_nxt_wd_fired = r_wd_fired;
        w_nxt_done_lat = 1'b0;
        w_wd_inc       = r_wd + 1'b1;
        w_done         = r_done_lat | dma_done;
        unique case (r_state)
            CPU_OWN: begin
                if (pclk1 && dma_req && halt_en)
                    w_nxt_state = HALT_REQ;
            end
            HALT_REQ: begin
                if (pclk1) begin
                    if (!dma_req) begin
                        w_nxt_state = RELEASE;
                    end else if (cpu_halted) begin
                        if (SETTLE_CYCLES == 0) begin
                            w_nxt_state = DMA_OWN;
                        end else begin
                            w_nxt_state  = SETTLE;
                            w_nxt_settle = 2'(SETTLE_CYCLES);
                        end
                    end
                end
            end
            SETTLE: begin
                if (pclk1) begin
                    if (r_settle <= 2'd1) begin
                        w_nxt_state  = DMA_OWN;
                        w_nxt_settle = '0;
                    end else begin
                        w_nxt_settle = r_settle - 2'd1;
                    end
                end
            end
            DMA_OWN: begin
                w_nxt_wd       = r_wd;
                w_nxt_done_lat = w_done;
                if (pclk1) begin
                    // A finished burst wins over the watchdog on the same strobe.
                    if (w_done) begin
                        w_nxt_state    = RELEASE;
                        w_nxt_done_lat = 1'b0;
                    end else begin
                        w_nxt_wd = w_wd_inc;
                        if (r_steal != 16'hFFFF)
                            w_nxt_steal = r_steal + 16'd1;
                        if (w_wd_inc == WDW'(MAX_DMA_CYCLES)) begin
                            w_nxt_state    = RELEASE;
                            w_nxt_wd_fired = 1'b1;
                        end
                    end
                end
            end
            RELEASE: begin
                if (pclk1 && !cpu_halted)
                    w_nxt_state = CPU_OWN;
            end
            default: begin
                w_nxt_state = CPU_OWN;
            end
        endcase
    end

    always_comb begin
        w_halt_n = 1'b1;
        w_grant  = 1'b0;
        w_ab     = cpu_AB;
        w_rw     = cpu_rwn;
        unique case (r_state)
            CPU_OWN: begin
                w_halt_n = 1'b1;
            end
            HALT_REQ: begin
                w_halt_n = 1'b0;
            end
            SETTLE: begin
                w_halt_n = 1'b0;
                w_ab     = r_held;
                w_rw     = 1'b1;
            end
            DMA_OWN: begin
                w_halt_n = 1'b0;
                w_grant  = 1'b1;
                w_ab     = maria_AB;
                w_rw     = 1'b1;
            end
            RELEASE: begin
                w_ab = r_held;
                w_rw = 1'b1;
            end
            default: begin
                w_halt_n = 1'b1;
            end
        endcase
        if (reset) begin
            w_halt_n = 1'b1;
            w_grant  = 1'b0;
            w_ab     = '0;
            w_rw     = 1'b1;
        end
    end

    assign cpu_halt_n  = w_halt_n;
    assign dma_grant   = w_grant;
    assign AB          = w_ab;
    assign RW          = w_rw;
    assign state_o     = r_state;
    assign steal_count = r_steal;
    assign wd_fired    = r_wd_fired;

endmodule

// File: tb/tb_sally_bus_arbiter.sv
// tb_sally_bus_arbiter: directed bench with an expectation queue drained by a monitor.
// Instance a has the default watchdog, instance b a 4-strobe watchdog.
module tb_sally_bus_arbiter;
  localparam int F_STATE = 0;
  localparam int F_HALTN = 1;
  localparam int F_GRANT = 2;
  localparam int F_AB    = 3;
  localparam int F_RW    = 4;
  localparam int F_STEAL = 5;
  localparam int F_WD    = 6;

  typedef struct {
    string       name;
    int unsigned dut;
    int unsigned fld;
    int unsigned exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pclk0 = 1'b0;
  logic        pclk1 = 1'b0;
  logic        halt_en = 1'b0;
  logic        dma_req = 1'b0;
  logic        dma_done = 1'b0;
  logic [15:0] cpu_AB = 16'h1F3A;
  logic        cpu_rwn = 1'b0;
  logic        cpu_halted = 1'b0;
  logic [15:0] maria_AB = 16'hC0DE;

  logic        a_halt_n, a_grant, a_rw, a_wd;
  logic [15:0] a_ab, a_steal;
  logic [2:0]  a_state;
  logic        b_halt_n, b_grant, b_rw, b_wd;
  logic [15:0] b_ab, b_steal;
  logic [2:0]  b_state;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sally_bus_arbiter #(.SETTLE_CYCLES(1), .MAX_DMA_CYCLES(512)) u_a (
    .clk_sys(clk), .reset(reset), .pclk0(pclk0), .pclk1(pclk1),
    .halt_en(halt_en), .dma_req(dma_req), .dma_done(dma_done),
    .cpu_AB(cpu_AB), .cpu_rwn(cpu_rwn), .cpu_halted(cpu_halted),
    .maria_AB(maria_AB), .cpu_halt_n(a_halt_n), .dma_grant(a_grant),
    .AB(a_ab), .RW(a_rw), .state_o(a_state), .steal_count(a_steal),
    .wd_fired(a_wd)
  );

  sally_bus_arbiter #(.SETTLE_CYCLES(1), .MAX_DMA_CYCLES(4)) u_b (
    .clk_sys(clk), .reset(reset), .pclk0(pclk0), .pclk1(pclk1),
    .halt_en(halt_en), .dma_req(dma_req), .dma_done(dma_done),
    .cpu_AB(cpu_AB), .cpu_rwn(cpu_rwn), .cpu_halted(cpu_halted),
    .maria_AB(maria_AB), .cpu_halt_n(b_halt_n), .dma_grant(b_grant),
    .AB(b_ab), .RW(b_rw), .state_o(b_state), .steal_count(b_steal),
    .wd_fired(b_wd)
  );

  function automatic int unsigned get(input int unsigned d,
                                      input int unsigned f);
    int unsigned v;
    v = 0;
    case (f)
      F_STATE: v = (d == 0) ? 32'(a_state)  : 32'(b_state);
      F_HALTN: v = (d == 0) ? 32'(a_halt_n) : 32'(b_halt_n);
      F_GRANT: v = (d == 0) ? 32'(a_grant)  : 32'(b_grant);
      F_AB:    v = (d == 0) ? 32'(a_ab)     : 32'(b_ab);
      F_RW:    v = (d == 0) ? 32'(a_rw)     : 32'(b_rw);
      F_STEAL: v = (d == 0) ? 32'(a_steal)  : 32'(b_steal);
      F_WD:    v = (d == 0) ? 32'(a_wd)     : 32'(b_wd);
      default: v = 32'hDEAD;
    endcase
    return v;
  endfunction

  initial begin
    exp_t        e;
    int unsigned act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = get(e.dut, e.fld);
        checks++;
        if (act != e.exp) begin
          failures++;
          $display("FAIL %s (dut %0d): got %0h expected %0h",
                   e.name, e.dut, act, e.exp);
        end
      end
    end
  end

  task automatic ck(input string n, input int unsigned got,
                    input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic ex(input string n, input int unsigned d,
                    input int unsigned f, input int unsigned v);
    exp_t e;
    e.name = n;
    e.dut  = d;
    e.fld  = f;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic chk();
    @(negedge clk);
    #1;
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic p1(input logic d = 1'b0);
    pclk1    = 1'b1;
    dma_done = d;
    @(posedge clk);
    #1;
    pclk1    = 1'b0;
    dma_done = 1'b0;
    @(posedge clk);
    #1;
    pclk0 = 1'b1;
    @(posedge clk);
    #1;
    pclk0 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    clk1();
  endtask

  task automatic to_dma();
    dma_req    = 1'b1;
    cpu_halted = 1'b1;
    halt_en    = 1'b1;
    p1();
    p1();
    p1();
  endtask

  initial begin
    clk1();
    ex("rst_state", 0, F_STATE, 0);
    ex("rst_haltn", 0, F_HALTN, 1);
    ex("rst_grant", 0, F_GRANT, 0);
    ex("rst_ab", 0, F_AB, 16'h0000);
    ex("rst_rw", 0, F_RW, 1);
    ex("rst_steal", 0, F_STEAL, 0);
    ex("rst_wd", 0, F_WD, 0);
    chk();
    ck("rst_d_state", 32'(a_state), 0);
    ck("rst_d_haltn", 32'(a_halt_n), 1);
    ck("rst_d_grant", 32'(a_grant), 0);
    ck("rst_d_ab", 32'(a_ab), 16'h0000);
    ck("rst_d_wd", 32'(a_wd), 0);
    reset = 1'b0;
    clk1();
    ex("cpu_ab", 0, F_AB, 16'h1F3A);
    ex("cpu_rw", 0, F_RW, 0);
    chk();

    halt_en = 1'b0;
    dma_req = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      p1();
      if (i == 50 || i == 100) begin
        ex("noen_state", 0, F_STATE, 0);
        ex("noen_haltn", 0, F_HALTN, 1);
        ex("noen_steal", 0, F_STEAL, 0);
        chk();
      end
    end
    dma_req = 1'b0;
    halt_en = 1'b1;
    clk1();

    cpu_halted = 1'b0;
    dma_req    = 1'b1;
    p1();
    ex("hreq_state", 0, F_STATE, 1);
    ex("hreq_haltn", 0, F_HALTN, 0);
    ex("hreq_grant", 0, F_GRANT, 0);
    ex("hreq_ab", 0, F_AB, 16'h1F3A);
    ex("hreq_rw", 0, F_RW, 0);
    chk();
    cpu_halted = 1'b1;
    p1();
    cpu_AB = 16'h2222;
    ex("settle_state", 0, F_STATE, 2);
    ex("settle_grant", 0, F_GRANT, 0);
    ex("settle_ab", 0, F_AB, 16'h1F3A);
    ex("settle_rw", 0, F_RW, 1);
    chk();
    p1();
    ex("dma_state", 0, F_STATE, 3);
    ex("dma_grant", 0, F_GRANT, 1);
    ex("dma_haltn", 0, F_HALTN, 0);
    ex("dma_ab", 0, F_AB, 16'hC0DE);
    ex("dma_rw", 0, F_RW, 1);
    chk();

    halt_en  = 1'b0;
    maria_AB = 16'h5A5A;
    for (int i = 1; i <= 10; i++) begin
      p1();
      if (i == 5) begin
        ex("burst5_steal", 0, F_STEAL, 5);
        chk();
      end
    end
    ex("burst_state", 0, F_STATE, 3);
    ex("burst_steal", 0, F_STEAL, 10);
    chk();
    dma_done = 1'b1;
    clk1();
    dma_done = 1'b0;
    dma_req  = 1'b0;
    ex("done_wait_state", 0, F_STATE, 3);
    chk();
    p1();
    maria_AB = 16'h0000;
    ex("rel_state", 0, F_STATE, 4);
    ex("rel_grant", 0, F_GRANT, 0);
    ex("rel_haltn", 0, F_HALTN, 1);
    ex("rel_ab", 0, F_AB, 16'h5A5A);
    ex("rel_rw", 0, F_RW, 1);
    ex("rel_steal", 0, F_STEAL, 10);
    chk();
    p1();
    ex("rel_hold_state", 0, F_STATE, 4);
    chk();
    cpu_halted = 1'b0;
    p1();
    ex("back_state", 0, F_STATE, 0);
    ex("back_ab", 0, F_AB, 16'h2222);
    chk();

    halt_en = 1'b1;
    dma_req = 1'b1;
    p1();
    ex("abort_hreq", 0, F_STATE, 1);
    chk();
    dma_req = 1'b0;
    p1();
    ex("abort_rel", 0, F_STATE, 4);
    ex("abort_rel_grant", 0, F_GRANT, 0);
    chk();
    p1();
    ex("abort_cpu", 0, F_STATE, 0);
    ex("abort_cpu_grant", 0, F_GRANT, 0);
    ex("abort_steal", 0, F_STEAL, 10);
    chk();

    rst_pulse();
    to_dma();
    p1();
    p1();
    p1();
    ex("wd3_state", 1, F_STATE, 3);
    ex("wd3_steal", 1, F_STEAL, 3);
    ex("wd3_fired", 1, F_WD, 0);
    chk();
    p1();
    ex("wd_state", 1, F_STATE, 4);
    ex("wd_grant", 1, F_GRANT, 0);
    ex("wd_fired", 1, F_WD, 1);
    ex("wd_steal", 1, F_STEAL, 4);
    chk();
    ck("wd_d_state", 32'(b_state), 4);
    ck("wd_d_fired", 32'(b_wd), 1);
    ck("wd_d_grant", 32'(b_grant), 0);
    dma_req    = 1'b0;
    cpu_halted = 1'b0;
    p1();
    ex("wd_back_state", 1, F_STATE, 0);
    ex("wd_sticky", 1, F_WD, 1);
    chk();

    rst_pulse();
    to_dma();
    p1();
    p1();
    p1();
    p1(1'b1);
    ex("tie_state", 1, F_STATE, 4);
    ex("tie_fired", 1, F_WD, 0);
    ex("tie_steal", 1, F_STEAL, 3);
    chk();
    dma_req    = 1'b0;
    cpu_halted = 1'b0;
    p1();

    rst_pulse();
    maria_AB = 16'h7777;
    to_dma();
    p1();
    p1();
    ex("pre_rst_state", 0, F_STATE, 3);
    ex("pre_rst_steal", 0, F_STEAL, 2);
    chk();
    clk1();
    reset = 1'b1;
    ex("arst_state", 0, F_STATE, 0);
    ex("arst_haltn", 0, F_HALTN, 1);
    ex("arst_grant", 0, F_GRANT, 0);
    ex("arst_ab", 0, F_AB, 16'h0000);
    ex("arst_rw", 0, F_RW, 1);
    ex("arst_steal", 0, F_STEAL, 0);
    chk();
    dma_req    = 1'b0;
    cpu_halted = 1'b0;
    reset      = 1'b0;
    clk1();
    chk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
